// File: rtl/digit_scan_pkg.sv
// -----------------------------------------------------------------------------
// digit_scan_pkg
//   Shared constants for the multiplexed 4-digit display scanner.
//   NUM_DIGITS  : number of scanned digits
//   SEL_W       : width of the digit index
//   AN_OFF      : anode pattern with every digit dark (anodes are active-low)
//   DIV_DEFAULT : default prescaler ratio (clk cycles per digit)
// -----------------------------------------------------------------------------
package digit_scan_pkg;

  localparam int NUM_DIGITS  = 4;
  localparam int SEL_W       = 2;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;
  localparam int DIV_DEFAULT = 100000;

  // One-hot (active-high) pattern for a digit index.
  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_DIGITS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/digit_scan_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//   Prescaler for the digit scanner. Counts 0..DIV-1 while en=1, wraps to 0,
//   and holds while en=0.
//   Ports:
//     clk  : system clock
//     rst  : asynchronous active-high reset (counter -> 0)
//     en   : count enable
//     tick : advance strobe, high during the cycle the counter sits at DIV-1
//            with en=1. It is decoded from the counter register so the parent
//            can register the visible tick together with the new digit index
//            on the same edge.
// -----------------------------------------------------------------------------
module tick_gen
  import digit_scan_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  // Keep a 1-bit counter for DIV=1 so the register always has a legal width.
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && at_last;

endmodule

// File: rtl/digit_scan.sv
// -----------------------------------------------------------------------------
// digit_scan
//   Scan controller for a multiplexed 4-digit display. A prescaler sets the
//   dwell per digit; at each advance the next enabled digit (circular search
//   starting after the current one) is selected and its anode driven low.
//   Ports:
//     clk   : system clock
//     rst   : asynchronous active-high reset
//     en    : scan enable; 0 freezes the scan and blanks all anodes
//     mask  : per-digit enable, mask[i]=1 includes digit i in the scan
//     sel   : current digit index (drives the downstream nibble mux)
//     an    : active-low anode drive, at most one bit low
//     tick  : one-cycle pulse on each digit advance (sel already updated)
//     frame : one-cycle pulse, with tick, when the scan wraps around
// -----------------------------------------------------------------------------
module digit_scan
  import digit_scan_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] mask,
  output logic [SEL_W-1:0]      sel,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  tick,
  output logic                  frame
);

  logic                  adv;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  tick_q, tick_d;
  logic                  frame_q, frame_d;

  logic [SEL_W-1:0]      nxt_sel;
  logic [SEL_W-1:0]      cand;
  logic                  found;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (adv)
  );

  // Circular search: candidates sel+1, sel+2, sel+3, then sel itself (the
  // 2-bit add wraps), so a lone enabled digit is re-selected.
  always_comb begin
    nxt_sel = sel_q;
    found   = 1'b0;
    cand    = sel_q;
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      cand = sel_q + SEL_W'(k);
      if (!found && mask[cand]) begin
        found   = 1'b1;
        nxt_sel = cand;
      end
    end
  end

  // The anode decode uses the index being loaded on this edge so that an
  // and sel always describe the same digit; mask is applied live, so a
  // digit dropped mid-dwell goes dark immediately but keeps sel until the
  // next advance.
  always_comb begin
    sel_d   = sel_q;
    tick_d  = 1'b0;
    frame_d = 1'b0;
    an_d    = AN_OFF;
    if (adv) begin
      tick_d  = 1'b1;
      sel_d   = nxt_sel;
      frame_d = found && (nxt_sel <= sel_q);
    end
    if (en) begin
      an_d = ~(mask & digit_onehot(sel_d));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= '0;
      an_q    <= AN_OFF;
      tick_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
    end
  end

  assign sel   = sel_q;
  assign an    = an_q;
  assign tick  = tick_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_digit_scan.sv
// -----------------------------------------------------------------------------
// tb_digit_scan
//   Self-checking bench for digit_scan with DIV=4: directed scenarios followed
//   by randomized en/mask/reset activity, all compared each cycle against a
//   behavioural model built from the scanning rules.
// -----------------------------------------------------------------------------
module tb_digit_scan;

  localparam int TB_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] mask;
  logic [1:0] sel;
  logic [3:0] an;
  logic       tick;
  logic       frame;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_pres, m_sel, m_tick, m_frame, m_an;
  int n_tick, n_frame;

  digit_scan #(.DIV(TB_DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mask  (mask),
    .sel   (sel),
    .an    (an),
    .tick  (tick),
    .frame (frame)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pres  = 0;
    m_sel   = 0;
    m_tick  = 0;
    m_frame = 0;
    m_an    = 15;
  endtask

  // One rising edge of the ideal scanner, from the inputs present at the edge.
  task automatic model_edge();
    int nsel;
    bit hit;
    if (rst) begin
      model_reset();
      return;
    end
    if (!en) begin
      m_tick  = 0;
      m_frame = 0;
      m_an    = 15;
      return;
    end
    m_tick  = (m_pres == TB_DIV - 1) ? 1 : 0;
    m_pres  = (m_pres + 1) % TB_DIV;
    m_frame = 0;
    if (m_tick == 1) begin
      hit  = 0;
      nsel = m_sel;
      for (int j = 1; j <= 4; j++) begin
        if (!hit && mask[(m_sel + j) % 4]) begin
          hit  = 1;
          nsel = (m_sel + j) % 4;
        end
      end
      if (hit && nsel <= m_sel) m_frame = 1;
      m_sel = nsel;
    end
    m_an = mask[m_sel] ? (15 & ~(1 << m_sel)) : 15;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_val("sel",   sel,   m_sel);
    check_val("an",    an,    m_an);
    check_val("tick",  tick,  m_tick);
    check_val("frame", frame, m_frame);
    n_tick  += tick;
    n_frame += frame;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 rst = 1'b1;
    #1;
    check_val({tag, "_sel"},   sel,   0);
    check_val({tag, "_an"},    an,    15);
    check_val({tag, "_tick"},  tick,  0);
    check_val({tag, "_frame"}, frame, 0);
    model_reset();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    bit seen;
    rst  = 1'b1;
    en   = 1'b0;
    mask = 4'h0;
    model_reset();
    n_tick  = 0;
    n_frame = 0;
    #12;
    check_val("rst_sel",   sel,   0);
    check_val("rst_an",    an,    15);
    check_val("rst_tick",  tick,  0);
    check_val("rst_frame", frame, 0);

    // Full mask: four advances 0->1->2->3->0, one wrap.
    rst  = 1'b0;
    en   = 1'b1;
    mask = 4'b1111;
    n_tick = 0; n_frame = 0;
    run(16);
    check_val("all_ticks",  n_tick,  4);
    check_val("all_frames", n_frame, 1);
    check_val("all_sel",    sel,     0);

    // Alternating digits 1 and 3.
    mask = 4'b1010;
    n_tick = 0; n_frame = 0;
    run(16);
    check_val("alt_frames", n_frame, 1);
    check_val("alt_sel",    sel,     3);

    // Single digit: sel parks on 2, frame with every tick.
    mask = 4'b0100;
    n_tick = 0; n_frame = 0;
    run(12);
    check_val("one_frames", n_frame, 3);
    check_val("one_sel",    sel,     2);
    check_val("one_an",     an,      4'b1011);

    // Empty mask: dark, sel held, ticks continue, no frames.
    mask = 4'b0000;
    n_tick = 0; n_frame = 0;
    run(8);
    check_val("zero_ticks",  n_tick,  2);
    check_val("zero_frames", n_frame, 0);
    check_val("zero_sel",    sel,     2);
    check_val("zero_an",     an,      15);

    // Drop the current digit mid-dwell.
    mask = 4'b1111;
    run(1);
    mask = 4'b1011;
    run(1);
    check_val("drop_an",  an,  15);
    check_val("drop_sel", sel, 2);
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      cycle();
      if (tick) seen = 1;
    end
    check_val("drop_tick_seen", seen, 1);
    check_val("drop_sel_next",  sel,  3);

    // Freeze mid-dwell, then resume.
    mask = 4'b1111;
    run(1);
    en = 1'b0;
    n_tick = 0; n_frame = 0;
    run(10);
    check_val("frz_ticks", n_tick, 0);
    check_val("frz_an",    an,     15);
    en = 1'b1;
    run(8);

    // Asynchronous reset mid-dwell.
    run(2);
    async_reset_pulse("arst");
    run(8);

    // Randomized activity.
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) mask = 4'($urandom);
      if ($urandom_range(0, 99) == 0) async_reset_pulse("rnd_rst");
      else cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digit_scan.md
DIGIT_SCAN -- requirements
Module: digit_scan

Interface
REQ-001 Parameter DIV, default 100000, prescaler divide ratio (clk cycles per digit); legal range DIV >= 1.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  scan enable; 0 freezes the scan and blanks the display.
REQ-005 mask  input  4  per-digit enable; mask[i]=1 means digit i takes part in the scan.
REQ-006 sel  output  2  current digit index; drives the select of the downstream 4:1 nibble mux.
REQ-007 an  output  4  anode drive, active-low, one-hot-low at most.
REQ-008 tick  output  1  one-cycle pulse marking each digit advance.
REQ-009 frame  output  1  one-cycle pulse marking completion of a full scan pass.

Function
REQ-010 The prescaler SHALL count 0..DIV-1 while en=1, wrap to 0 after DIV-1, and hold its value while en=0.
REQ-011 tick SHALL be registered and high for exactly one cycle, in the cycle after the prescaler reaches DIV-1; with DIV=1 tick is high every cycle while en=1.
REQ-012 Whenever tick is high, sel SHALL already hold the new index: the first i with mask[i]=1, searching circularly from old sel+1 through old sel.
REQ-013 If only the current digit is enabled, the search in REQ-012 SHALL return the current index, so sel holds.
REQ-014 If mask=4'b0000, sel SHALL hold its value; tick still pulses, and frame stays 0.
REQ-015 frame SHALL pulse coincident with tick when new sel <= old sel (wrap-around, including the single-enabled-digit case) and mask is not zero.
REQ-016 an SHALL be registered, with an[i]=0 only when en=1, mask[i]=1 and i equals the sel value for the same cycle; otherwise an[i]=1.
REQ-017 A digit removed from mask mid-dwell SHALL blank on the next clock edge; sel SHALL leave it only at the next tick.
REQ-018 A digit added to mask SHALL be considered at the next tick; it does not preempt the current dwell.
REQ-019 When en falls, tick and frame SHALL be 0 and an SHALL be 4'b1111 from the next edge; sel and the prescaler SHALL hold.
REQ-020 When en rises again, scanning SHALL resume from the held prescaler and sel values.

Reset
REQ-021 When rst asserts, the outputs SHALL immediately take: prescaler=0, sel=2'b00, an=4'b1111, tick=0, frame=0.
REQ-022 rst SHALL override en in every cycle; a reset mid-dwell or mid-pass discards all scan progress.
REQ-023 On the first edge after rst deasserts with en=1, the prescaler SHALL begin counting from 0.
REQ-024 On that same edge, an SHALL drive digit 0 if mask[0]=1.

Structure
REQ-025 The shared constants header SHALL hold the digit count (4), the sel width (2), the anode-off pattern (4'b1111) and the default DIV.
REQ-026 The prescaler SHALL be a sub-module tick_gen, with parameter DIV and ports clk, rst, en and tick.
REQ-027 The digit search and anode decode SHALL live in digit_scan.
REQ-028 The total RTL SHALL be 120-400 lines.

Verification (DIV=4)
REQ-029 Scenario: rst pulse, then en=1 and mask=1111 for 20 cycles. Required: tick every 4th cycle; sel goes 0,1,2,3,0; an steps 1110,1101,1011,0111; frame pulses once, on the 3->0 step.
REQ-030 Scenario: mask=1010. Required: sel alternates 1,3,1; an alternates 1101 and 0111; frame pulses on each 3->1 step.
REQ-031 Scenario: mask=0100. Required: sel=2 is held; an=1011 steady; frame pulses with every tick.
REQ-032 Scenario: mask=0000. Required: an=1111; sel is unchanged; frame=0.
REQ-033 Scenario: mask changes 1111->1011 while sel=2. Required: an=1111 on the next edge; sel=3 at the next tick.
REQ-034 Scenario: en=0 for 10 cycles mid-dwell, then en=1. Required: an=1111, tick=0, sel held; on resume the next tick arrives after the remaining dwell cycles.
REQ-035 Scenario: rst asserted asynchronously mid-dwell. Required: sel=00 and an=1111 before the next clock edge.
